// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU op encodings and slot state.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; output forced to zero while held in reset.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             reset_n,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] res_s;

    assign shamt_s = op2[SHW-1:0];

    // Operation decode; unknown codes produce zero
    always_comb begin
        res_s = {WIDTH{1'b0}};
        case (alu_ctrl)
            ALU_ADD:  res_s = op1 + op2;
            ALU_SUB:  res_s = op1 - op2;
            ALU_SLL:  res_s = op1 << shamt_s;
            ALU_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: res_s = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  res_s = op1 ^ op2;
            ALU_SRL:  res_s = op1 >> shamt_s;
            ALU_SRA:  res_s = $unsigned($signed(op1) >>> shamt_s);
            ALU_OR:   res_s = op1 | op2;
            ALU_AND:  res_s = op1 & op2;
            default:  res_s = {WIDTH{1'b0}};
        endcase
    end

    // Output gating and zero flag
    always_comb begin
        if (reset_n) begin
            result = res_s;
        end else begin
            result = {WIDTH{1'b0}};
        end
        zero = (result == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a one-entry result slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_op1,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_op2,
    input  logic [NUM_REQ-1:0][3:0]         req_alu_ctrl,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [WIDTH-1:0]                rsp_result,
    output logic                            rsp_zero
);

    slot_state_e      state_r;
    logic             owner_r;
    logic             ptr_r;
    logic [1:0]       grant_s;
    logic             sel_s;
    logic             drain_s;
    logic             slot_free_s;
    logic             accept_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_zero_s;

    // Grant depends only on valids and the round-robin pointer
    always_comb begin
        grant_s = 2'b00;
        case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Slot availability and request handshake
    always_comb begin
        sel_s       = grant_s[1];
        drain_s     = (state_r == ST_FULL) && rsp_ready[owner_r];
        slot_free_s = (state_r == ST_EMPTY) || drain_s;
        if (reset) begin
            req_ready = 2'b00;
        end else if (slot_free_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
        accept_s = |req_ready;
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .reset_n  (~reset),
        .op1      (req_op1[sel_s]),
        .op2      (req_op2[sel_s]),
        .alu_ctrl (req_alu_ctrl[sel_s]),
        .result   (alu_result_s),
        .zero     (alu_zero_s)
    );

    // Slot, owner and pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_EMPTY;
            owner_r    <= 1'b0;
            ptr_r      <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_result <= {WIDTH{1'b0}};
            rsp_zero   <= 1'b0;
        end else if (accept_s) begin
            // A new accept overwrites the slot even if it drains this cycle
            state_r    <= ST_FULL;
            owner_r    <= sel_s;
            ptr_r      <= ~sel_s;
            rsp_valid  <= sel_s ? 2'b10 : 2'b01;
            rsp_result <= alu_result_s;
            rsp_zero   <= alu_zero_s;
        end else if (drain_s) begin
            state_r   <= ST_EMPTY;
            rsp_valid <= 2'b00;
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with hand-computed expected values.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_op1;
    logic [1:0][31:0] req_op2;
    logic [1:0][3:0]  req_alu_ctrl;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;

    int vectors;
    int miscompares;

    alu_arbiter #(.WIDTH(32), .NUM_REQ(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_alu_ctrl (req_alu_ctrl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] v, input logic [31:0] r, input logic z);
        chk({tag, ".rsp_valid"}, {30'd0, rsp_valid}, {30'd0, v});
        chk({tag, ".rsp_result"}, rsp_result, r);
        chk({tag, ".rsp_zero"}, {31'd0, rsp_zero}, {31'd0, z});
    endtask

    task automatic chk_rdy(input string tag, input logic [1:0] exp);
        #1;
        chk({tag, ".req_ready"}, {30'd0, req_ready}, {30'd0, exp});
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_alu_ctrl[i] = op;
        req_op1[i]      = a;
        req_op2[i]      = b;
    endtask

    logic [3:0]  s_op  [4];
    logic [31:0] s_a   [4];
    logic [31:0] s_b   [4];
    logic [31:0] s_exp [4];

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        req_valid    = 2'b00;
        rsp_ready    = 2'b00;
        req_op1      = '0;
        req_op2      = '0;
        req_alu_ctrl = '0;

        // reset state
        tick();
        tick();
        chk_rsp("reset", 2'b00, 32'h0, 1'b0);
        req_valid = 2'b11;
        chk_rdy("reset_ready", 2'b00);
        req_valid = 2'b00;
        reset = 1'b0;
        tick();

        // requester 0 ADD
        set_req(0, ALU_ADD, 32'h0000000A, 32'h00000005);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        chk_rdy("add", 2'b01);
        tick();
        req_valid = 2'b00;
        chk_rsp("add", 2'b01, 32'h0000000F, 1'b0);
        tick();
        chk("add_drain.rsp_valid", {30'd0, rsp_valid}, 32'd0);

        // requester 1 SUB giving zero
        set_req(1, ALU_SUB, 32'h0000000A, 32'h0000000A);
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        chk_rdy("sub", 2'b10);
        tick();
        req_valid = 2'b00;
        chk_rsp("sub", 2'b10, 32'h00000000, 1'b1);
        tick();
        chk("sub_drain.rsp_valid", {30'd0, rsp_valid}, 32'd0);

        // both valid after reset: alternation starting with requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, ALU_AND, 32'h0000FFFF, 32'h0F0F0F0F);
        set_req(1, ALU_OR,  32'h0000FFFF, 32'hFFFF0000);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        chk_rdy("rr0", 2'b01);
        tick();
        chk_rsp("rr0", 2'b01, 32'h00000F0F, 1'b0);
        chk_rdy("rr1", 2'b10);
        tick();
        chk_rsp("rr1", 2'b10, 32'hFFFFFFFF, 1'b0);
        chk_rdy("rr2", 2'b01);
        tick();
        chk_rsp("rr2", 2'b01, 32'h00000F0F, 1'b0);
        req_valid = 2'b00;
        tick();
        chk("rr_drain.rsp_valid", {30'd0, rsp_valid}, 32'd0);

        // backpressure: result held three cycles, both requesters blocked
        set_req(0, ALU_SLL, 32'h00000001, 32'h00000008);
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        chk_rdy("sll", 2'b01);
        tick();
        set_req(0, ALU_ADD, 32'h00000002, 32'h00000003);
        set_req(1, ALU_XOR, 32'h00000001, 32'h00000001);
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            rsp_ready = (c == 1) ? 2'b10 : 2'b00;
            chk_rdy("hold", 2'b00);
            chk_rsp("hold", 2'b01, 32'h00000100, 1'b0);
            tick();
        end
        chk_rsp("hold_end", 2'b01, 32'h00000100, 1'b0);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        chk_rdy("drain_accept", 2'b01);
        tick();
        req_valid = 2'b00;
        chk_rsp("drain_accept", 2'b01, 32'h00000005, 1'b0);
        tick();
        chk("hold_drain.rsp_valid", {30'd0, rsp_valid}, 32'd0);

        // reset while FULL discards the pending result
        set_req(0, ALU_SRA, 32'h80000000, 32'h00000004);
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        chk_rsp("sra", 2'b01, 32'hF8000000, 1'b0);
        reset = 1'b1;
        tick();
        chk_rsp("sra_reset", 2'b00, 32'h0, 1'b0);
        reset = 1'b0;
        rsp_ready = 2'b11;
        tick();
        chk("post_reset.rsp_valid", {30'd0, rsp_valid}, 32'd0);
        req_valid = 2'b11;
        chk_rdy("post_reset_ptr", 2'b01);
        req_valid = 2'b00;
        tick();
        chk("withdrawn.rsp_valid", {30'd0, rsp_valid}, 32'd0);

        // back-to-back stream from requester 0
        s_op[0] = ALU_SLT;  s_a[0] = 32'h00000005; s_b[0] = 32'h0000000A; s_exp[0] = 32'h00000001;
        s_op[1] = ALU_SLTU; s_a[1] = 32'h00000005; s_b[1] = 32'hFFFFFFFF; s_exp[1] = 32'h00000001;
        s_op[2] = ALU_XOR;  s_a[2] = 32'hAAAAAAAA; s_b[2] = 32'h55555555; s_exp[2] = 32'hFFFFFFFF;
        s_op[3] = ALU_SRL;  s_a[3] = 32'h0000F000; s_b[3] = 32'h00000004; s_exp[3] = 32'h00000F00;
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            set_req(0, s_op[k], s_a[k], s_b[k]);
            chk_rdy("stream", 2'b01);
            tick();
            chk_rsp("stream", 2'b01, s_exp[k], 1'b0);
        end
        req_valid = 2'b00;
        tick();
        chk("stream_drain.rsp_valid", {30'd0, rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter NUM_REQ, fixed at 2, requester count; no other value supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  [1:0]  requester i presents an operation.
REQ-006 req_ready  output  [1:0]  arbiter accepts requester i's operation this cycle.
REQ-007 req_op1  input  2 x WIDTH  first operand per requester.
REQ-008 req_op2  input  2 x WIDTH  second operand per requester.
REQ-009 req_alu_ctrl  input  2 x 4  ALU op code per requester, package encoding.
REQ-010 rsp_valid  output  [1:0]  result available for requester i.
REQ-011 rsp_ready  input  [1:0]  requester i consumes result.
REQ-012 rsp_result  output  WIDTH  registered ALU result, shared by both responders.
REQ-013 rsp_zero  output  1  registered ALU zero flag.

Function
REQ-014 Handshake: transfer on req_valid[i] && req_ready[i]; response transfer on rsp_valid[i] && rsp_ready[i].
REQ-015 One result slot; slot free when empty or drained (owner rsp_ready high) in same cycle.
REQ-016 req_ready[i] = slot free && grant[i]; at most one req_ready bit high per cycle.
REQ-017 Grant: single valid requester wins; both valid -> requester indicated by round-robin pointer wins.
REQ-018 Pointer changes only on accepted request: set to the non-granted index; otherwise holds.
REQ-019 Grant is work-conserving and independent of req_alu_ctrl and operand values.
REQ-020 Accepted op1/op2/alu_ctrl drive the ALU combinationally; result and zero captured into slot on the accepting edge.
REQ-021 Latency: accept at edge k -> rsp_valid[owner] high, rsp_result/rsp_zero valid, in cycle after edge k.
REQ-022 rsp_valid one-hot or zero; only the owner bit asserts.
REQ-023 rsp_result, rsp_zero, rsp_valid held stable while rsp_ready[owner] low.
REQ-024 rsp_ready on non-owner bit ignored.
REQ-025 Drain and accept in same cycle: new result replaces old, rsp_valid stays high (owner may change); throughput 1 op/cycle with rsp_ready held high.
REQ-026 req_valid dropped before acceptance: no state change; requester may change operands freely until accepted.
REQ-027 alu_ctrl codes outside package encoding forwarded unchanged; result as defined by alu.
REQ-028 States: EMPTY (slot free) and FULL (result held); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain+accept or no drain.

Reset
REQ-029 On reset: rsp_valid = 2'b00, rsp_result = 0, rsp_zero = 0, pointer = 0 (requester 0 priority), state EMPTY.
REQ-030 req_ready = 2'b00 while reset high.
REQ-031 Reset during FULL discards pending result; no response delivered afterwards.

Structure
REQ-032 Shared package holds alu_ctrl encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, plus the state enum.
REQ-033 One sub-module instance: alu (WIDTH), its reset_n driven by ~reset.
REQ-034 Arbitration, pointer and slot register in alu_arbiter; no other sub-modules.

Verification
REQ-035 Req0 ADD op1=0x0000000A op2=0x00000005, rsp_ready=2'b01 -> next cycle rsp_valid=2'b01, rsp_result=0x0000000F, rsp_zero=0.
REQ-036 Req1 SUB 0x0000000A-0x0000000A -> rsp_valid=2'b10, rsp_result=0x00000000, rsp_zero=1.
REQ-037 Both valid after reset (req0 AND 0x0000FFFF,0x0F0F0F0F; req1 OR 0x0000FFFF,0xFFFF0000), rsp_ready=2'b11 -> req0 first (0x00000F0F), req1 next cycle (0xFFFFFFFF), then alternation while both valid.
REQ-038 rsp_ready low 3 cycles with result 0x00000100 (SLL 1,8) pending -> rsp held stable, req_ready=2'b00 for all 3 cycles, delivered on 4th.
REQ-039 Reset asserted while FULL (SRA 0x80000000>>4 = 0xF8000000 pending) -> next cycle rsp_valid=2'b00, rsp_result=0, pointer=0.
REQ-040 Back-to-back: req0 streams 4 ops (SLT 5<10, SLTU 5<0xFFFFFFFF, XOR 0xAAAAAAAA^0x55555555, SRL 0x0000F000>>4), rsp_ready high -> results 1, 1, 0xFFFFFFFF, 0x00000F00 on 4 consecutive cycles.
